data_mem_handler: RTL
=====================

Name: data_mem_handler

Overview:
- Memory-side responder for the ALU's load/store address outputs.
- Takes the ALU-computed read/write address, store data and access width, and runs one request/acknowledge transaction on the data-memory bus.
- Returns a sign- or zero-extended load result.
- Holds the pc stalled (drives its Disable) while a transaction is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16, max cycles in ACCESS waiting for bus_ack before aborting with err.
- CNT_W, 5, width of timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock
- clr  in  1  reset, asynchronous, active-low
- mem_read  in  1  current instruction is a load
- mem_write  in  1  current instruction is a store
- funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- read_address  in  32  load address from ALU
- write_address  in  32  store address from ALU
- store_data  in  32  rs2 value to store
- bus_rdata  in  32  read data from memory, valid when bus_ack=1
- bus_ack  in  1  memory completes the request this cycle
- bus_addr  out  32  word-aligned address {addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_sel  out  4  byte-lane enables
- bus_re  out  1  read request
- bus_we  out  1  write request
- load_data  out  32  extended load result
- stall  out  1  to pc Disable; hold PC
- done  out  1  one-cycle pulse, transaction finished
- err  out  1  one-cycle pulse with done: misaligned, illegal funct3 or timeout

Behaviour:
- Reset (clr=0, async): state=IDLE, counter=0, latched address/data/sel cleared. All outputs 0: bus_addr, bus_wdata, bus_sel, bus_re, bus_we, load_data, done, err. stall=0.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If mem_write=1 (priority over mem_read), latch write_address, store_data and funct3.
  - Else if mem_read=1, latch read_address and funct3.
  - stall is combinational: 1 in IDLE whenever mem_read|mem_write=1, so the pc holds in the same cycle.
  - Legal and aligned access -> ACCESS. Otherwise -> DONE with err set.
- Legality and alignment:
  - Loads accept funct3 000/001/010/100/101. Stores accept 000/001/010.
  - H requires addr[0]=0. W requires addr[1:0]=00.
  - Illegal or misaligned accesses never assert bus_re or bus_we.
- Byte select:
  - B/BU: bus_sel = 4'b0001 << addr[1:0].
  - H/HU: bus_sel = addr[1] ? 1100 : 0011.
  - W: bus_sel = 1111.
- Store data: B replicates store_data[7:0] into all four lanes. H replicates [15:0] into both halves. W passes through.
- ACCESS:
  - bus_re or bus_we held at 1; bus_addr, bus_sel and bus_wdata held stable.
  - stall=1. Counter increments each cycle.
  - bus_ack=1 -> DONE; on load, capture the extended lane into load_data.
  - Counter reaches TIMEOUT_CYCLES-1 without ack -> DONE with err. load_data is left unchanged.
- Load extension: select lane by latched addr[1:0] or addr[1]. B/H sign-extend, BU/HU zero-extend, W passes through.
- DONE (one cycle):
  - done=1; err=1 if aborted. bus_re=bus_we=0. stall=0, so the pc advances at this edge. Counter cleared.
  - Next state IDLE. mem_read/mem_write are ignored in DONE.
- load_data is registered and holds until the next successful load; stores and errors do not change it.
- Latency: with ack on the first ACCESS cycle, stall is high for 2 cycles (IDLE-detect, ACCESS) and done appears in cycle 3.
- bus_ack while in IDLE or DONE is ignored.
- A clr drop mid-ACCESS drops bus_re/bus_we immediately; no done pulse is produced.

Test Plan:
- LW read_address=0x100, bus_rdata=0xDEADBEEF, ack on 1st ACCESS cycle -> bus_sel=1111, bus_re for 1 cycle, stall 2 cycles, done in cycle 3, load_data=0xDEADBEEF.
- LB addr=0x103, bus_rdata=0x80xxxxxx -> bus_sel=1000, bus_addr=0x100, load_data=0xFFFFFF80. LBU same access -> 0x00000080.
- SH write_address=0x202, store_data=0x1234ABCD, ack after 3 wait cycles -> bus_sel=1100, bus_wdata=0xABCDABCD, bus_we held 4 cycles, stall 5 cycles, done=1, err=0, load_data unchanged.
- SW addr=0x101, and LH addr=0x011 -> no bus_we/bus_re; done=1 and err=1 in the cycle after detect.
- mem_read=1 with no ack -> ACCESS exactly 16 cycles, then done=1 and err=1. mem_read and mem_write both high -> write performed.
- clr=0 during ACCESS -> bus_re=0 immediately, state IDLE, stall=0, no done pulse.

Source files
------------

// File: rtl/data_mem_handler_if.sv
// Data-memory bus between the load/store handler and memory.
// master: handler drives addr/wdata/sel/re/we; slave: memory returns rdata/ack.
interface data_mem_handler_if;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_sel;
    logic        bus_re;
    logic        bus_we;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    modport master (
        output bus_addr, bus_wdata, bus_sel, bus_re, bus_we,
        input  bus_rdata, bus_ack
    );

    modport slave (
        input  bus_addr, bus_wdata, bus_sel, bus_re, bus_we,
        output bus_rdata, bus_ack
    );
endinterface

// File: rtl/data_mem_handler.sv
// Load/store responder: one req/ack bus transaction per access, pc stall while busy.
// Ports: clk, clr (async low), mem_read/mem_write/funct3/addresses/store_data in,
//        bus (master), load_data, stall, done, err out.
module data_mem_handler #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [2:0]          funct3,
    input  logic [31:0]         read_address,
    input  logic [31:0]         write_address,
    input  logic [31:0]         store_data,
    data_mem_handler_if.master  bus,
    output logic [31:0]         load_data,
    output logic                stall,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state, state_n;
    logic            req, wr, legal, timeout;
    logic [31:0]     addr_in, wdata_in, ext;
    logic [3:0]      sel_in;
    logic [7:0]      lane_b;
    logic [15:0]     lane_h;

    logic [31:0]     addr_q, wdata_q;
    logic [3:0]      sel_q;
    logic [2:0]      f3_q;
    logic            wr_q, err_q;
    logic [CNT_W-1:0] cnt;

    // Store wins when both requests are raised together.
    assign req     = mem_read | mem_write;
    assign wr      = mem_write;
    assign addr_in = wr ? write_address : read_address;
    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        legal = 1'b0;
        case (funct3)
            3'b000:  legal = 1'b1;
            3'b001:  legal = ~addr_in[0];
            3'b010:  legal = (addr_in[1:0] == 2'b00);
            3'b100:  legal = ~wr;
            3'b101:  legal = ~wr & ~addr_in[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        sel_in   = 4'b1111;
        wdata_in = store_data;
        case (funct3[1:0])
            2'b00: begin
                sel_in   = 4'b0001 << addr_in[1:0];
                wdata_in = {4{store_data[7:0]}};
            end
            2'b01: begin
                sel_in   = addr_in[1] ? 4'b1100 : 4'b0011;
                wdata_in = {2{store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        lane_b = bus.bus_rdata[7:0];
        case (addr_q[1:0])
            2'b01:   lane_b = bus.bus_rdata[15:8];
            2'b10:   lane_b = bus.bus_rdata[23:16];
            2'b11:   lane_b = bus.bus_rdata[31:24];
            default: ;
        endcase
        lane_h = addr_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
        case (f3_q)
            3'b000:  ext = {{24{lane_b[7]}}, lane_b};
            3'b100:  ext = {24'd0, lane_b};
            3'b001:  ext = {{16{lane_h[15]}}, lane_h};
            3'b101:  ext = {16'd0, lane_h};
            default: ext = bus.bus_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (req) state_n = legal ? ACCESS : DONE;
            ACCESS:  if (bus.bus_ack || timeout) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            sel_q     <= '0;
            f3_q      <= '0;
            wr_q      <= 1'b0;
            err_q     <= 1'b0;
            cnt       <= '0;
            load_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr_in;
                        wdata_q <= wdata_in;
                        sel_q   <= sel_in;
                        f3_q    <= funct3;
                        wr_q    <= wr;
                        err_q   <= ~legal;
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 1'b1;
                    if (bus.bus_ack) begin
                        if (!wr_q) load_data <= ext;
                    end else if (timeout) begin
                        err_q <= 1'b1;
                    end
                end
                DONE: begin
                    cnt   <= '0;
                    err_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.bus_addr  = {addr_q[31:2], 2'b00};
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_sel   = sel_q;
    assign bus.bus_re    = (state == ACCESS) & ~wr_q;
    assign bus.bus_we    = (state == ACCESS) & wr_q;

    // Combinational in IDLE so the pc holds on the detect cycle itself.
    assign stall = clr & (((state == IDLE) & req) | (state == ACCESS));
    assign done  = (state == DONE);
    assign err   = (state == DONE) & err_q;

endmodule
